md5_block_padder: RTL and testbench



---
 rtl/md5_pkg.sv | 16 +
 rtl/md5_tail_word.sv | 25 ++
 rtl/md5_block_padder.sv | 167 ++++++++++++++++
 tb/tb_md5_block_padder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 message block padder.
package md5_pkg;

  localparam int         MD5_BLOCK_W    = 512;
  localparam int         MD5_WORDS      = 16;
  localparam int         MD5_LEN_W      = 64;
  localparam logic [7:0] MD5_PAD_MARKER = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_EMIT,
    ST_EMIT_LAST
  } md5_pad_state_t;

endpackage

// File: rtl/md5_tail_word.sv
// Keeps the first n bytes of a little-endian word, places the 0x80 marker at
// byte n when n < 4 and clears everything above it.
module md5_tail_word
  import md5_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  n,
  output logic [31:0] word,
  output logic        marker_placed
);

  always_comb begin
    word          = '0;
    marker_placed = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(n)) begin
        word[8*k +: 8] = data[8*k +: 8];
      end else if (k == int'(n)) begin
        word[8*k +: 8] = MD5_PAD_MARKER;
        marker_placed  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/md5_block_padder.sv
// Packs a 32-bit little-endian word stream into 512-bit MD5 blocks and
// appends the 0x80 marker, zero fill and 64-bit bit length on the final word.
module md5_block_padder
  import md5_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_data,
  input  logic [2:0]             in_bytes,
  input  logic                   in_last,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  output logic [MD5_BLOCK_W-1:0] blk_data,
  output logic                   blk_last
);

  md5_pad_state_t       state;
  md5_pad_state_t       state_next;
  logic [31:0]          blk_buf [MD5_WORDS];
  // One extra bit: a tail marker written into word 15 leaves w at 16.
  logic [4:0]           w;
  logic [MD5_LEN_W-1:0] len;
  logic                 mark_done;
  logic                 pad_pending;

  logic [2:0]           n_sat;
  logic [31:0]          tail_data;
  logic [2:0]           tail_n;
  logic [31:0]          tail_word;
  logic                 tail_marker;
  logic [5:0]           pad_w_next;
  logic                 pad_fits;

  function automatic logic [2:0] sat_bytes(input logic [2:0] b);
    return (b > 3'd4) ? 3'd4 : b;
  endfunction

  assign n_sat = sat_bytes(in_bytes);

  // PAD reuses the tail masker with n=0 to produce a bare 0x00000080 word;
  // non-last words pass through unchanged with n=4.
  assign tail_data  = (state == ST_PAD) ? 32'd0 : in_data;
  assign tail_n     = (state == ST_PAD) ? 3'd0 : (in_last ? n_sat : 3'd4);
  assign pad_w_next = {1'b0, w} + {5'd0, ~mark_done};
  assign pad_fits   = (pad_w_next <= 6'd14);

  md5_tail_word u_tail (
    .data          (tail_data),
    .n             (tail_n),
    .word          (tail_word),
    .marker_placed (tail_marker)
  );

  always_comb begin
    for (int i = 0; i < MD5_WORDS; i++) begin
      blk_data[32*i +: 32] = blk_buf[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    blk_valid  = 1'b0;
    blk_last   = 1'b0;
    unique case (state)
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!in_last) begin
            if (w == 5'd15) state_next = ST_EMIT;
          end else if (w == 5'd15 && n_sat == 3'd4) begin
            state_next = ST_EMIT;
          end else begin
            state_next = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        state_next = pad_fits ? ST_EMIT_LAST : ST_EMIT;
      end
      ST_EMIT: begin
        blk_valid = 1'b1;
        if (blk_ready) state_next = pad_pending ? ST_PAD : ST_FILL;
      end
      ST_EMIT_LAST: begin
        blk_valid = 1'b1;
        blk_last  = 1'b1;
        if (blk_ready) state_next = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MD5_WORDS; i++) begin
        blk_buf[i] <= '0;
      end
      w           <= '0;
      len         <= '0;
      mark_done   <= 1'b0;
      pad_pending <= 1'b0;
    end else begin
      unique case (state)
        ST_FILL: begin
          if (in_valid) begin
            blk_buf[w[3:0]] <= tail_word;
            if (!in_last) begin
              len <= len + 64'd32;
              w   <= w + 5'd1;
            end else begin
              len       <= len + {58'd0, n_sat, 3'b000};
              mark_done <= tail_marker;
              if (w == 5'd15 && n_sat == 3'd4) begin
                pad_pending <= 1'b1;
              end else begin
                w <= w + 5'd1;
              end
            end
          end
        end
        ST_PAD: begin
          if (!mark_done) begin
            blk_buf[w[3:0]] <= tail_word;
            mark_done       <= 1'b1;
          end
          for (int i = 0; i < MD5_WORDS; i++) begin
            if (pad_fits) begin
              if (6'(i) >= pad_w_next && 6'(i) <= 6'd13) blk_buf[i] <= '0;
            end else if (6'(i) >= pad_w_next) begin
              blk_buf[i] <= '0;
            end
          end
          if (pad_fits) begin
            blk_buf[14] <= len[31:0];
            blk_buf[15] <= len[63:32];
          end else begin
            pad_pending <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (blk_ready) begin
            w           <= '0;
            pad_pending <= 1'b0;
          end
        end
        ST_EMIT_LAST: begin
          if (blk_ready) begin
            w         <= '0;
            len       <= '0;
            mark_done <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_block_padder.sv
// Randomized bench for md5_block_padder against a byte-level MD5 padding model.
module tb_md5_block_padder;
  import md5_pkg::*;

  typedef logic [7:0] bytes_t [$];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  md5_block_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           ready_mode = 1;  // 0 random, 1 always ready, 2 stalled
  logic [511:0] exp_q[$];
  bit           exp_last_q[$];
  logic [511:0] got_q[$];
  bit           got_last_q[$];
  logic [31:0]  cur_wd[$];
  logic [2:0]   cur_nb[$];
  bit           cur_last[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [511:0] b, input int i);
    return b[32*i +: 32];
  endfunction

  // Reference: append 0x80, zero to 56 mod 64, then the 64-bit bit length LE.
  function automatic void model_push(input bytes_t msg);
    bytes_t       p;
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nblk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 64; j++) blk[8*j +: 8] = p[64*b + j];
      exp_q.push_back(blk);
      exp_last_q.push_back(b == nblk - 1);
    end
  endfunction

  // Splits a message into stream words; junk fills bytes beyond the tail.
  function automatic void build_words(input bytes_t msg, input bit empty_tail);
    int          len_b;
    int          full;
    int          rem;
    int          nonlast;
    bit          tail_n4;
    logic [31:0] x;
    len_b   = msg.size();
    full    = len_b / 4;
    rem     = len_b % 4;
    tail_n4 = (rem == 0) && (len_b > 0) && !empty_tail;
    nonlast = tail_n4 ? full - 1 : full;
    cur_wd.delete();
    cur_nb.delete();
    cur_last.delete();
    for (int i = 0; i < nonlast; i++) begin
      cur_wd.push_back({msg[4*i+3], msg[4*i+2], msg[4*i+1], msg[4*i]});
      cur_nb.push_back(3'($urandom_range(0, 7)));
      cur_last.push_back(1'b0);
    end
    if (tail_n4) begin
      cur_wd.push_back({msg[4*full-1], msg[4*full-2], msg[4*full-3], msg[4*full-4]});
      cur_nb.push_back(3'($urandom_range(4, 7)));
    end else begin
      x = $urandom;
      for (int k = 0; k < rem; k++) x[8*k +: 8] = msg[4*full + k];
      cur_wd.push_back(x);
      cur_nb.push_back(3'(rem));
    end
    cur_last.push_back(1'b1);
  endfunction

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input bit last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = nb;
    in_last  = last;
    while (!in_ready) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        $display("FAIL in_ready_timeout: got 0 expected 1");
        $fatal(1, "input stream stalled");
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    in_bytes = 3'($urandom_range(0, 7));
  endtask

  task automatic send_range(input int a, input int b, input bit gap);
    for (int i = a; i < b; i++) begin
      send_word(cur_wd[i], cur_nb[i], cur_last[i]);
      if (gap && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic send_msg(input bytes_t msg, input bit empty_tail, input bit gap);
    build_words(msg, empty_tail);
    model_push(msg);
    send_range(0, cur_wd.size(), gap);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    exp_last_q.delete();
    @(negedge clk);
  endtask

  function automatic bytes_t rand_bytes(input int n);
    bytes_t m;
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  // Consumer: drives blk_ready and compares every accepted block to the model.
  initial begin
    logic [511:0] prev_data;
    bit           prev_valid;
    bit           prev_ready;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    blk_ready  = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       blk_ready = ($urandom_range(0, 3) != 0);
        1:       blk_ready = 1'b1;
        default: blk_ready = 1'b0;
      endcase
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (blk_valid && prev_valid && !prev_ready) check("blk_stable", blk_data, prev_data);
        if (blk_valid && blk_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_block", blk_valid, 1'b0);
          end else begin
            check("blk_data", blk_data, exp_q.pop_front());
            check("blk_last", blk_last, exp_last_q.pop_front());
          end
          got_q.push_back(blk_data);
          got_last_q.push_back(blk_last);
        end
        prev_valid = blk_valid;
        prev_ready = blk_ready;
        prev_data  = blk_data;
      end
    end
  end

  initial begin
    bytes_t       m;
    string        s;
    logic [511:0] d0;
    int           t;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_bytes = '0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_blk_valid", blk_valid, 1'b0);
    check("rst_blk_last", blk_last, 1'b0);
    check("rst_blk_data", blk_data, '0);
    rst = 1'b0;
    @(negedge clk);
    ready_mode = 1;

    // Empty message
    got_q.delete(); got_last_q.delete();
    m.delete();
    send_msg(m, 1'b0, 1'b0);
    wait_drain();
    check("empty_nblk", got_q.size(), 1);
    check("empty_blk", got_q[0], 512'h80);
    check("empty_last", got_last_q[0], 1'b1);

    // 55-byte text message
    s = "Hello ENPM808! This is my MD5 implementation in verilog";
    m.delete();
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    model_push(m);
    check("model_hello_w13", wd(exp_q[0], 13), 32'h80676f6c);
    check("model_hello_w14", wd(exp_q[0], 14), 32'h000001b8);
    exp_q.delete(); exp_last_q.delete();
    got_q.delete(); got_last_q.delete();
    send_msg(m, 1'b0, 1'b0);
    wait_drain();
    check("hello_nblk", got_q.size(), 1);
    check("hello_w0", wd(got_q[0], 0), 32'h6c6c6548);
    check("hello_w13", wd(got_q[0], 13), 32'h80676f6c);
    check("hello_w14", wd(got_q[0], 14), 32'h000001b8);
    check("hello_w15", wd(got_q[0], 15), 32'h0);
    check("hello_last", got_last_q[0], 1'b1);

    // 56 bytes: marker lands in word 14, length needs a second block
    got_q.delete(); got_last_q.delete();
    send_msg(rand_bytes(56), 1'b0, 1'b0);
    wait_drain();
    check("b56_nblk", got_q.size(), 2);
    check("b56_1_w14", wd(got_q[0], 14), 32'h80);
    check("b56_1_w15", wd(got_q[0], 15), 32'h0);
    check("b56_1_last", got_last_q[0], 1'b0);
    check("b56_2_low", got_q[1][447:0], '0);
    check("b56_2_w14", wd(got_q[1], 14), 32'h1c0);
    check("b56_2_last", got_last_q[1], 1'b1);

    // 64 bytes: data block, then marker + length block
    m = rand_bytes(64);
    got_q.delete(); got_last_q.delete();
    send_msg(m, 1'b0, 1'b0);
    wait_drain();
    check("b64_nblk", got_q.size(), 2);
    check("b64_1_w0", wd(got_q[0], 0), {m[3], m[2], m[1], m[0]});
    check("b64_1_w15", wd(got_q[0], 15), {m[63], m[62], m[61], m[60]});
    check("b64_1_last", got_last_q[0], 1'b0);
    check("b64_2_w0", wd(got_q[1], 0), 32'h80);
    check("b64_2_w14", wd(got_q[1], 14), 32'h200);
    check("b64_2_w15", wd(got_q[1], 15), 32'h0);
    check("b64_2_last", got_last_q[1], 1'b1);

    // Consumer stall on a full block with the next word already offered
    ready_mode = 2;
    m = rand_bytes(70);
    build_words(m, 1'b0);
    model_push(m);
    send_range(0, 16, 1'b0);
    t = 0;
    while (!blk_valid && t < 20) begin @(negedge clk); t++; end
    check("stall_valid", blk_valid, 1'b1);
    d0 = blk_data;
    check("stall_w0", wd(d0, 0), {m[3], m[2], m[1], m[0]});
    in_valid = 1'b1;
    in_data  = cur_wd[16];
    in_bytes = cur_nb[16];
    in_last  = cur_last[16];
    repeat (10) begin
      @(negedge clk);
      check("stall_data", blk_data, d0);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_blk_valid", blk_valid, 1'b1);
    end
    ready_mode = 1;
    send_range(16, cur_wd.size(), 1'b0);
    wait_drain();

    // Reset while a block is held
    ready_mode = 2;
    build_words(rand_bytes(80), 1'b0);
    send_range(0, 16, 1'b0);
    t = 0;
    while (!blk_valid && t < 20) begin @(negedge clk); t++; end
    #2 rst = 1'b1;
    #1;
    check("rst_held_blk_valid", blk_valid, 1'b0);
    check("rst_held_blk_data", blk_data, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset with w=7 mid-message
    ready_mode = 1;
    build_words(rand_bytes(40), 1'b0);
    send_range(0, 7, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_in_ready", in_ready, 1'b1);
    check("rst_mid_blk_valid", blk_valid, 1'b0);
    check("rst_mid_blk_last", blk_last, 1'b0);
    check("rst_mid_blk_data", blk_data, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.delete(); exp_last_q.delete();
    got_q.delete(); got_last_q.delete();
    m.delete();
    m.push_back(8'ha5);
    send_msg(m, 1'b0, 1'b0);
    wait_drain();
    check("one_byte_nblk", got_q.size(), 1);
    check("one_byte_w0", wd(got_q[0], 0), 32'h000080a5);
    check("one_byte_w14", wd(got_q[0], 14), 32'h8);
    check("one_byte_last", got_last_q[0], 1'b1);

    // Random messages with random gaps and random back-pressure
    ready_mode = 0;
    got_q.delete(); got_last_q.delete();
    for (int k = 0; k < 30; k++) begin
      send_msg(rand_bytes($urandom_range(0, 150)), 1'($urandom_range(0, 1)), 1'b1);
    end
    ready_mode = 1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
